// File: rtl/gon_collector.sv
// gon_collector: gathers PE results and serialises them onto one tagged enable/ready stream.
// Build option: define GON_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module gon_collector #(
    parameter int XBUS_NUMS = 12,
    parameter int PE_NUMS   = 14,
    parameter int ID_LEN    = 5,
    parameter int ROW_LEN   = 4,
    parameter int VALUE_LEN = 32
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [(VALUE_LEN+1)*XBUS_NUMS*PE_NUMS-1:0] pe_enable_data,
    output logic [XBUS_NUMS*PE_NUMS-1:0]               pe_ready,
    output logic                                        enable,
    input  logic                                        ready,
    output logic [ROW_LEN-1:0]                          row_tag,
    output logic [ID_LEN-1:0]                           col_tag,
    output logic [VALUE_LEN-1:0]                        value,
    input  logic                                        set_id,
    input  logic [ID_LEN-1:0]                           id_scan_in,
    output logic [ID_LEN-1:0]                           id_scan_out,
    input  logic                                        set_row,
    input  logic [ROW_LEN-1:0]                          row_scan_in,
    output logic [ROW_LEN-1:0]                          row_scan_out
);
    localparam int N  = XBUS_NUMS * PE_NUMS;
    localparam int SW = VALUE_LEN + 1;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int RW = (XBUS_NUMS > 1) ? $clog2(XBUS_NUMS) : 1;

    logic [N-1:0]         pe_en;
    logic [VALUE_LEN-1:0] pe_val [N];

    logic [ID_LEN-1:0]    col_id_q [N];
    logic [ID_LEN-1:0]    col_id_d [N];
    logic [ROW_LEN-1:0]   row_id_q [XBUS_NUMS];
    logic [ROW_LEN-1:0]   row_id_d [XBUS_NUMS];
    logic [IW-1:0]        ptr_q, ptr_d;
    logic                 enable_q, enable_d;
    logic [VALUE_LEN-1:0] value_q, value_d;
    logic [ROW_LEN-1:0]   row_tag_q, row_tag_d;
    logic [ID_LEN-1:0]    col_tag_q, col_tag_d;

    logic          free;
    logic          found;
    logic          grant_valid;
    logic [IW:0]   cand;
    logic [IW-1:0] grant_idx;
    logic [RW-1:0] grant_row;

    for (genvar n = 0; n < N; n++) begin : g_unpack
        assign pe_en[n]  = pe_enable_data[n*SW + VALUE_LEN];
        assign pe_val[n] = pe_enable_data[n*SW +: VALUE_LEN];
    end

    // Both ID chains shift toward the highest index; the tail feeds the scan output.
    assign col_id_d[0] = set_id ? id_scan_in : col_id_q[0];
    for (genvar n = 1; n < N; n++) begin : g_col_chain
        assign col_id_d[n] = set_id ? col_id_q[n-1] : col_id_q[n];
    end

    assign row_id_d[0] = set_row ? row_scan_in : row_id_q[0];
    for (genvar r = 1; r < XBUS_NUMS; r++) begin : g_row_chain
        assign row_id_d[r] = set_row ? row_id_q[r-1] : row_id_q[r];
    end

    // NOTE: every variable in a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int i = 0; i < N; i++) begin
`ifdef GON_FIXED_PRIO_EN
            cand = (IW+1)'(i);
`else
            cand = {1'b0, ptr_q} + (IW+1)'(i);
            if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
`endif
            if (!found && pe_en[cand[IW-1:0]]) begin
                found     = 1'b1;
                grant_idx = cand[IW-1:0];
            end
        end
        grant_row = '0;
        for (int r = 1; r < XBUS_NUMS; r++) begin
            if (grant_idx >= IW'(r * PE_NUMS)) grant_row = RW'(r);
        end
    end

    always_comb begin
        free        = !enable_q || ready;
        grant_valid = free && found && !rst;
        pe_ready    = '0;
        if (grant_valid) pe_ready[grant_idx] = 1'b1;

        enable_d  = enable_q;
        value_d   = value_q;
        row_tag_d = row_tag_q;
        col_tag_d = col_tag_q;
        ptr_d     = ptr_q;
        if (grant_valid) begin
            enable_d  = 1'b1;
            value_d   = pe_val[grant_idx];
            row_tag_d = row_id_q[grant_row];
            col_tag_d = col_id_q[grant_idx];
`ifdef GON_FIXED_PRIO_EN
            ptr_d     = '0;
`else
            ptr_d     = (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
`endif
        end else if (enable_q && ready) begin
            enable_d = 1'b0;
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the ID arrays are reset because tags and scan outputs must read zero after reset.
            col_id_q  <= '{default: '0};
            row_id_q  <= '{default: '0};
            ptr_q     <= '0;
            enable_q  <= 1'b0;
            value_q   <= '0;
            row_tag_q <= '0;
            col_tag_q <= '0;
        end else begin
            col_id_q  <= col_id_d;
            row_id_q  <= row_id_d;
            ptr_q     <= ptr_d;
            enable_q  <= enable_d;
            value_q   <= value_d;
            row_tag_q <= row_tag_d;
            col_tag_q <= col_tag_d;
        end
    end

    assign enable       = enable_q;
    assign value        = value_q;
    assign row_tag      = row_tag_q;
    assign col_tag      = col_tag_q;
    assign id_scan_out  = col_id_q[N-1];
    assign row_scan_out = row_id_q[XBUS_NUMS-1];

endmodule
